lmfe_col_gen: RTL and testbench

- Upstream stage of the local median filter engine. Accepts the raster pixel stream (Din/in_en/busy), keeps the last K-1 image rows in a line store, and emits one K-tall vertical pixel column per output pixel.
- Vertical border pixels in each column are zero-padded.
- The downstream sliding-window/median sorter consumes the columns through a valid/ready handshake and handles horizontal padding itself.

---
 rtl/lmfe_pkg.sv | 45 ++++
 rtl/lmfe_col_gen_if.sv | 26 ++
 rtl/lmfe_line_store.sv | 27 ++
 rtl/lmfe_col_gen.sv | 140 ++++++++++++++
 tb/tb_lmfe_col_gen.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/lmfe_pkg.sv
// Shared constants, state encoding and helpers for the local median filter
// engine column generator.
package lmfe_pkg;

    localparam int WIDTH  = 128;
    localparam int HEIGHT = 128;
    localparam int K      = 7;
    localparam int HALF   = K / 2;
    localparam int DW     = 8;

    localparam int X_W    = $clog2(WIDTH);
    localparam int Y_W    = $clog2(HEIGHT);
    // Row counter keeps counting past the last image row while flushing.
    localparam int R_W    = $clog2(HEIGHT + HALF + 1);
    localparam int SLOTS  = K - 1;
    localparam int S_W    = $clog2(SLOTS);

    typedef enum logic [1:0] {
        FILL,
        STREAM,
        FLUSH
    } state_t;

    // Slot holding row (r - SLOTS + i) when row r lives in slot s.
    function automatic logic [S_W-1:0] slot_add(
        input logic [S_W-1:0] s,
        input int             i
    );
        int t;
        t = int'(s) + i;
        if (t >= SLOTS) t = t - SLOTS;
        return S_W'(t);
    endfunction

    // Row (r - SLOTS + i) lies inside the image.
    function automatic logic row_live(
        input logic [R_W-1:0] r,
        input int             i
    );
        int t;
        t = int'(r) - SLOTS + i;
        return (t >= 0) && (t < HEIGHT);
    endfunction

endpackage

// File: rtl/lmfe_col_gen_if.sv
// Pixel input and column output handshake bundle of the column generator.
// master = upstream/downstream side, slave = the generator itself.
interface lmfe_col_gen_if;
    import lmfe_pkg::*;

    logic [DW-1:0]   Din;
    logic            in_en;
    logic            busy;
    logic            col_valid;
    logic            col_ready;
    logic [K*DW-1:0] col_data;
    logic [X_W-1:0]  col_x;
    logic [Y_W-1:0]  col_y;
    logic            frame_done;

    modport master (
        output Din, in_en, col_ready,
        input  busy, col_valid, col_data, col_x, col_y, frame_done
    );

    modport slave (
        input  Din, in_en, col_ready,
        output busy, col_valid, col_data, col_x, col_y, frame_done
    );

endinterface

// File: rtl/lmfe_line_store.sv
// Line store: K-1 rows of WIDTH pixels, one write port, and a combinational
// read of every slot at a single column.
module lmfe_line_store
    import lmfe_pkg::*;
(
    input  logic                     clk,
    input  logic                     we,
    input  logic [S_W-1:0]           wslot,
    input  logic [X_W-1:0]           wx,
    input  logic [DW-1:0]            wdata,
    input  logic [X_W-1:0]           rx,
    output logic [SLOTS-1:0][DW-1:0] rd
);

    logic [DW-1:0] mem [SLOTS][WIDTH];

    // Contents survive reset; stale rows are masked by the reader.
    always_ff @(posedge clk) begin
        if (we) mem[wslot][wx] <= wdata;
    end

    // Read all slots at the current column (old data when written same cycle).
    always_comb begin
        for (int s = 0; s < SLOTS; s++) rd[s] = mem[s][rx];
    end

endmodule

// File: rtl/lmfe_col_gen.sv
// Column generator: buffers K-1 rows and emits one zero-padded K-tall column
// per pixel position, flushing the bottom HALF rows after the last input.
module lmfe_col_gen
    import lmfe_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    lmfe_col_gen_if.slave bus
);

    state_t                   state;
    state_t                   state_nx;
    logic [X_W-1:0]           x;
    logic [R_W-1:0]           row;
    logic [S_W-1:0]           slot;

    logic                     valid_q;
    logic [K*DW-1:0]          data_q;
    logic [X_W-1:0]           cx_q;
    logic [Y_W-1:0]           cy_q;
    logic                     done_q;

    logic                     busy;
    logic                     accept;
    logic                     load;
    logic                     step;
    logic                     x_end;
    logic                     last_hs;
    logic [SLOTS-1:0][DW-1:0] rd;
    logic [K*DW-1:0]          data_nx;

    assign busy    = (state == FLUSH) | (valid_q & ~bus.col_ready);
    assign accept  = bus.in_en & ~busy;
    assign x_end   = (x == X_W'(WIDTH - 1));
    assign last_hs = valid_q & bus.col_ready
                   & (cx_q == X_W'(WIDTH - 1))
                   & (cy_q == Y_W'(HEIGHT - 1));
    // Flush stops loading once the last center row has been issued.
    assign load    = ((state == STREAM) & accept)
                   | ((state == FLUSH) & (~valid_q | bus.col_ready)
                      & (row < R_W'(HEIGHT + HALF)));
    assign step    = accept | load;

    lmfe_line_store u_store (
        .clk   (clk),
        .we    (accept),
        .wslot (slot),
        .wx    (x),
        .wdata (bus.Din),
        .rx    (x),
        .rd    (rd)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FILL;
        else       state <= state_nx;
    end

    // Next-state: prime rows, stream, then drain the bottom border.
    always_comb begin
        state_nx = state;
        unique case (state)
            FILL:
                if (accept & x_end & (row == R_W'(HALF - 1)))
                    state_nx = STREAM;
            STREAM:
                if (accept & x_end & (row == R_W'(HEIGHT - 1)))
                    state_nx = FLUSH;
            FLUSH:
                if (last_hs) state_nx = FILL;
            default:
                state_nx = FILL;
        endcase
    end

    // Raster position of the newest row; slot tracks row mod (K-1).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x    <= '0;
            row  <= '0;
            slot <= '0;
        end else if ((state == FLUSH) & last_hs) begin
            x    <= '0;
            row  <= '0;
            slot <= '0;
        end else if (step) begin
            if (x_end) begin
                x    <= '0;
                row  <= row + R_W'(1);
                slot <= (slot == S_W'(SLOTS - 1)) ? '0 : slot + S_W'(1);
            end else begin
                x    <= x + X_W'(1);
            end
        end
    end

    // Assemble the column: stored rows on top, live pixel at the bottom,
    // rows outside the image forced to zero.
    always_comb begin
        data_nx = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (row_live(row, i))
                data_nx[(K-1-i)*DW +: DW] = rd[slot_add(slot, i)];
        end
        if (state == STREAM) data_nx[DW-1:0] = bus.Din;
    end

    // Output register: holds under backpressure, reloads on the same
    // edge as a handshake for full-rate streaming.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= data_nx;
            cx_q    <= x;
            cy_q    <= Y_W'(row - R_W'(HALF));
        end else if (valid_q & bus.col_ready) begin
            valid_q <= 1'b0;
        end
    end

    // One-cycle pulse after the final column of a frame is taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) done_q <= 1'b0;
        else       done_q <= last_hs;
    end

    assign bus.busy       = busy;
    assign bus.col_valid  = valid_q;
    assign bus.col_data   = data_q;
    assign bus.col_x      = cx_q;
    assign bus.col_y      = cy_q;
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_lmfe_col_gen.sv
// Scoreboard bench for lmfe_col_gen: frames of directed pixels, expected
// columns queued at issue time and checked by an independent monitor.
module tb_lmfe_col_gen;
    import lmfe_pkg::*;

    typedef struct {
        logic [K*DW-1:0] d;
        int              x;
        int              y;
        int              kind;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    lmfe_col_gen_if bus ();

    lmfe_col_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t            q[$];
    int              errors = 0;
    int              checks = 0;
    int              ncols = 0;
    int              nfd = 0;
    int              bp = 0;
    bit              rnd = 1'b0;
    bit              fd_pend = 1'b0;
    bit              hold = 1'b0;
    bit              lat_once = 1'b1;
    bit              bp_once = 1'b1;
    logic [K*DW-1:0] pd;
    logic [X_W-1:0]  px;
    logic [Y_W-1:0]  py;

    function automatic logic [DW-1:0] pix(input int kind, input int y, input int x);
        if (kind == 1) return 8'hAA;
        return DW'((y * WIDTH + x) & 255);
    endfunction

    function automatic logic [K*DW-1:0] golden(input int kind, input int cy, input int cx);
        logic [K*DW-1:0] c;
        c = '0;
        for (int i = 0; i < K; i++) begin
            int r;
            r = cy - HALF + i;
            if (r >= 0 && r < HEIGHT) c[(K-1-i)*DW +: DW] = pix(kind, r, cx);
        end
        return c;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input int kind);
        for (int y = 0; y < HEIGHT; y++) begin
            for (int x = 0; x < WIDTH; x++) begin
                exp_t e;
                e.d = golden(kind, y, x);
                e.x = x;
                e.y = y;
                e.kind = kind;
                q.push_back(e);
            end
        end
    endtask

    task automatic send_pixel(input logic [DW-1:0] v);
        int n;
        n = 0;
        bus.Din = v;
        bus.in_en = 1'b1;
        @(negedge clk);
        while (bus.busy) begin
            n++;
            if (n > 4000) begin
                $display("FAIL in_timeout actual=busy required=idle");
                $fatal(1, "input stalled");
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.in_en = 1'b0;
    endtask

    task automatic send_frame(input int kind, input int last);
        for (int idx = 0; idx <= last; idx++) begin
            if (kind == 0 && bp_once && idx == 40 * WIDTH + 60) begin
                bp = 5;
                bp_once = 1'b0;
            end
            send_pixel(pix(kind, idx / WIDTH, idx % WIDTH));
            if (lat_once && idx == HALF * WIDTH - 1)
                chk("lat_pre", 64'(bus.col_valid), 64'd0);
            if (lat_once && idx == HALF * WIDTH) begin
                chk("lat_first", 64'(bus.col_valid), 64'd1);
                lat_once = 1'b0;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || fd_pend) && n < 6000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_left", 64'(q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Downstream ready: forced-low window, random, or always high.
    initial begin
        bus.col_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (bp > 0) begin
                bus.col_ready = 1'b0;
                bp--;
            end else begin
                bus.col_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // Monitor: compare every handshaked column against the queue.
    always @(negedge clk) begin
        if (reset) begin
            hold = 1'b0;
            fd_pend = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_data", 64'(bus.col_data), 64'(pd));
                chk("hold_x", 64'(bus.col_x), 64'(px));
                chk("hold_y", 64'(bus.col_y), 64'(py));
            end
            if (bus.frame_done || fd_pend) begin
                chk("frame_done", 64'(bus.frame_done), 64'(fd_pend));
                if (bus.frame_done) nfd++;
            end
            fd_pend = 1'b0;
            if (bus.col_valid && !bus.col_ready)
                chk("busy_bp", 64'(bus.busy), 64'd1);
            if (bus.col_valid && bus.col_ready) begin : pop
                exp_t e;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_col actual=(%0d,%0d) required=none",
                             bus.col_y, bus.col_x);
                end else begin
                    e = q.pop_front();
                    chk("col_data", 64'(bus.col_data), 64'(e.d));
                    chk("col_x", 64'(bus.col_x), 64'(e.x));
                    chk("col_y", 64'(bus.col_y), 64'(e.y));
                    if (e.kind == 0 && e.y == 0 && e.x == 0)
                        chk("col_0_0", 64'(bus.col_data), 64'h00000000800080);
                    if (e.kind == 0 && e.y == 127 && e.x == 5)
                        chk("col_127_5", 64'(bus.col_data), 64'h05850585000000);
                    if (e.kind == 1 && e.y == 0)
                        chk("aa_top", 64'(bus.col_data), 64'h000000AAAAAAAA);
                    if (e.y >= HEIGHT - HALF)
                        chk("flush_busy", 64'(bus.busy), 64'd1);
                    if (e.y == HEIGHT - 1 && e.x == WIDTH - 1) fd_pend = 1'b1;
                end
                ncols++;
            end
            hold = bus.col_valid && !bus.col_ready;
            pd = bus.col_data;
            px = bus.col_x;
            py = bus.col_y;
        end
    end

    initial begin
        int base;
        bus.Din = '0;
        bus.in_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(bus.col_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.frame_done), 64'd0);
        chk("rst_data", 64'(bus.col_data), 64'd0);
        chk("rst_xy", 64'({bus.col_y, bus.col_x}), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        push_frame(0);
        send_frame(0, WIDTH * HEIGHT - 1);
        push_frame(1);
        send_frame(1, WIDTH * HEIGHT - 1);
        drain();
        chk("count_ab", 64'(ncols), 64'(2 * WIDTH * HEIGHT));
        chk("fd_ab", 64'(nfd), 64'd2);

        push_frame(0);
        send_frame(0, 5000);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 64'(bus.col_valid), 64'd0);
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;

        base = ncols;
        rnd = 1'b1;
        push_frame(0);
        send_frame(0, WIDTH * HEIGHT - 1);
        drain();
        chk("count_d", 64'(ncols - base), 64'(WIDTH * HEIGHT));
        chk("fd_total", 64'(nfd), 64'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
